// File: rtl/stack_alu_param.sv
// Signed evaluation stack ALU: a valid/ready command port, registered result/error pulses,
// and a serial shift-add multiplier that stalls the command port while it runs.
module stack_alu_param #(
    parameter int N     = 4,
    parameter int DEPTH = 16,
    parameter int SPW   = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            opcode,
    input  logic signed [N-1:0]   in_data,
    output logic                  out_valid,
    output logic signed [N-1:0]   out_data,
    output logic                  overflow,
    output logic                  error,
    output logic [SPW-1:0]        sp,
    output logic                  full,
    output logic                  empty
);
    // Handshake: a command is taken on any rising edge with in_valid && in_ready;
    // the sender holds opcode/in_data steady until then. There is no output backpressure.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(N + 1);
    localparam int PW = 2 * N;
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_PUSH = 4'b0001;
    localparam logic [3:0] OP_POP  = 4'b0010;
    localparam logic [3:0] OP_DUP  = 4'b0011;
    localparam logic [3:0] OP_SWAP = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b0111;
    localparam logic [3:0] OP_NEG  = 4'b1000;
    localparam logic [3:0] OP_CLR  = 4'b1001;

    typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_WB} state_t;
    state_t r_state, w_state_next;

    logic [N-1:0]   r_stack [DEPTH];
    logic [SPW-1:0] r_sp;
    logic [CW-1:0]  r_cnt;
    logic [PW-1:0]  r_acc, r_mcand;
    logic [N-1:0]   r_mplier;
    logic           r_neg;
    logic           r_out_valid, r_overflow, r_error;
    logic [N-1:0]   r_out_data;

    logic [AW-1:0]  w_top_idx, w_sec_idx, w_push_idx, w_wr_idx;
    logic [N-1:0]   w_t, w_s, w_mag_t, w_mag_s, w_wr_data, w_res;
    logic [N:0]     w_sum, w_diff, w_negt;
    logic [PW-1:0]  w_prod;
    logic [SPW-1:0] w_sp_next;
    logic           w_accept, w_full, w_has1, w_has2, w_mul_ovf;
    logic           w_legal, w_wr_en, w_swap, w_emit, w_ovf, w_mul_start;

    assign in_ready   = (r_state == IDLE);
    assign w_accept   = in_valid && in_ready;
    assign w_full     = (r_sp == SP_FULL);
    assign w_has1     = (r_sp != '0);
    assign w_has2     = (r_sp >= SPW'(2));
    assign w_top_idx  = AW'(r_sp - SPW'(1));
    assign w_sec_idx  = AW'(r_sp - SPW'(2));
    assign w_push_idx = AW'(r_sp);
    assign w_t        = r_stack[w_top_idx];
    assign w_s        = r_stack[w_sec_idx];

    // Sign-extended by one bit so the carry-out exposes signed overflow.
    assign w_sum   = {w_s[N-1], w_s} + {w_t[N-1], w_t};
    assign w_diff  = {w_s[N-1], w_s} - {w_t[N-1], w_t};
    assign w_negt  = (N+1)'(0) - {w_t[N-1], w_t};
    assign w_mag_t = w_t[N-1] ? (~w_t + N'(1)) : w_t;
    assign w_mag_s = w_s[N-1] ? (~w_s + N'(1)) : w_s;

    assign w_prod    = r_neg ? (~r_acc + PW'(1)) : r_acc;
    assign w_mul_ovf = !((&w_prod[PW-1:N-1]) || (~|w_prod[PW-1:N-1]));

    always_comb begin
        w_legal     = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_idx    = w_push_idx;
        w_wr_data   = in_data;
        w_sp_next   = r_sp;
        w_swap      = 1'b0;
        w_emit      = 1'b0;
        w_res       = w_t;
        w_ovf       = 1'b0;
        w_mul_start = 1'b0;
        case (opcode)
            OP_NOP: w_legal = 1'b1;
            OP_PUSH: if (!w_full) begin
                w_legal = 1'b1; w_wr_en = 1'b1; w_sp_next = r_sp + SPW'(1);
            end
            OP_POP: if (w_has1) begin
                w_legal = 1'b1; w_emit = 1'b1; w_sp_next = r_sp - SPW'(1);
            end
            OP_DUP: if (w_has1 && !w_full) begin
                w_legal = 1'b1; w_wr_en = 1'b1; w_wr_data = w_t; w_sp_next = r_sp + SPW'(1);
            end
            OP_SWAP: if (w_has2) begin
                w_legal = 1'b1; w_swap = 1'b1;
            end
            OP_ADD, OP_SUB: if (w_has2) begin
                w_legal   = 1'b1;
                w_wr_en   = 1'b1;
                w_wr_idx  = w_sec_idx;
                w_wr_data = (opcode == OP_ADD) ? w_sum[N-1:0] : w_diff[N-1:0];
                w_res     = w_wr_data;
                w_ovf     = (opcode == OP_ADD) ? (w_sum[N] ^ w_sum[N-1]) : (w_diff[N] ^ w_diff[N-1]);
                w_emit    = 1'b1;
                w_sp_next = r_sp - SPW'(1);
            end
            OP_MUL: if (w_has2) begin
                w_legal = 1'b1; w_mul_start = 1'b1;
            end
            OP_NEG: if (w_has1) begin
                w_legal   = 1'b1;
                w_wr_en   = 1'b1;
                w_wr_idx  = w_top_idx;
                w_wr_data = w_negt[N-1:0];
                w_res     = w_negt[N-1:0];
                w_ovf     = w_negt[N] ^ w_negt[N-1];
                w_emit    = 1'b1;
            end
            OP_CLR: begin
                w_legal = 1'b1; w_sp_next = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_mul_start) w_state_next = MUL_RUN;
            MUL_RUN: if (r_cnt == CW'(1)) w_state_next = MUL_WB;
            MUL_WB:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sp        <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_neg       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_overflow  <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= 1'b0;
            r_error     <= 1'b0;
            case (r_state)
                IDLE: if (w_accept) begin
                    if (w_legal) begin
                        r_sp <= w_sp_next;
                        if (w_emit) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_res;
                            r_overflow  <= w_ovf;
                        end
                        if (w_mul_start) begin
                            r_cnt    <= CW'(N);
                            r_acc    <= '0;
                            r_mcand  <= {{N{1'b0}}, w_mag_s};
                            r_mplier <= w_mag_t;
                            r_neg    <= w_s[N-1] ^ w_t[N-1];
                        end
                    end else begin
                        r_error <= 1'b1;
                    end
                end
                MUL_RUN: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CW'(1);
                end
                MUL_WB: begin
                    r_sp        <= r_sp - SPW'(1);
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_prod[N-1:0];
                    r_overflow  <= w_mul_ovf;
                end
                default: ;
            endcase
        end
    end

    // Storage is deliberately unreset; entries at or above sp are meaningless.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == IDLE && w_accept && w_legal) begin
                if (w_wr_en) r_stack[w_wr_idx] <= w_wr_data;
                if (w_swap) begin
                    r_stack[w_top_idx] <= w_s;
                    r_stack[w_sec_idx] <= w_t;
                end
            end else if (r_state == MUL_WB) begin
                r_stack[w_sec_idx] <= w_prod[N-1:0];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign overflow  = r_overflow;
    assign error     = r_error;
    assign sp        = r_sp;
    assign full      = w_full;
    assign empty     = (r_sp == '0);
endmodule

// File: tb/tb_stack_alu_param.sv
// Bench for stack_alu_param: directed scenarios plus random commands against a queue-based
// integer model of the stack.
module tb_stack_alu_param;
    localparam int N     = 4;
    localparam int DEPTH = 16;
    localparam int SPW   = $clog2(DEPTH + 1);

    localparam int OP_NOP = 0, OP_PUSH = 1, OP_POP = 2, OP_DUP = 3, OP_SWAP = 4;
    localparam int OP_ADD = 5, OP_SUB = 6, OP_MUL = 7, OP_NEG = 8, OP_CLR = 9;

    logic                clk = 1'b0;
    logic                rst, in_valid, in_ready, out_valid, overflow, error, full, empty;
    logic [3:0]          opcode;
    logic signed [N-1:0] in_data, out_data;
    logic [SPW-1:0]      sp;

    stack_alu_param #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .in_data(in_data), .out_valid(out_valid), .out_data(out_data), .overflow(overflow),
        .error(error), .sp(sp), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int mstack[$];

    logic         ov, of, er;
    logic [N-1:0] od;
    int           busy;
    logic         ev, eo, ee;
    int           ed, ebusy;

    function automatic int wrapn(input int x);
        int m;
        m = x & ((1 << N) - 1);
        if (m >= (1 << (N - 1))) m = m - (1 << N);
        return m;
    endfunction

    function automatic bit fits(input int x);
        return (x >= -(1 << (N - 1))) && (x <= (1 << (N - 1)) - 1);
    endfunction

    // Reference model: stack as a queue of integers, top at the back.
    task automatic model_apply(input int op, input int val);
        int t, s, r;
        ev = 1'b0; eo = 1'b0; ee = 1'b0; ed = 0; ebusy = 0;
        case (op)
            OP_NOP: ;
            OP_PUSH: if (mstack.size() < DEPTH) mstack.push_back(wrapn(val)); else ee = 1'b1;
            OP_POP: if (mstack.size() >= 1) begin ed = mstack.pop_back(); ev = 1'b1; end
                    else ee = 1'b1;
            OP_DUP: if (mstack.size() >= 1 && mstack.size() < DEPTH) mstack.push_back(mstack[$]);
                    else ee = 1'b1;
            OP_SWAP: if (mstack.size() >= 2) begin
                t = mstack.pop_back(); s = mstack.pop_back();
                mstack.push_back(t); mstack.push_back(s);
            end else ee = 1'b1;
            OP_ADD, OP_SUB, OP_MUL: if (mstack.size() >= 2) begin
                t = mstack.pop_back(); s = mstack.pop_back();
                r = (op == OP_ADD) ? s + t : (op == OP_SUB) ? s - t : s * t;
                mstack.push_back(wrapn(r));
                ev = 1'b1; ed = wrapn(r); eo = !fits(r);
                if (op == OP_MUL) ebusy = N + 1;
            end else ee = 1'b1;
            OP_NEG: if (mstack.size() >= 1) begin
                t = mstack.pop_back(); r = -t;
                mstack.push_back(wrapn(r));
                ev = 1'b1; ed = wrapn(r); eo = !fits(r);
            end else ee = 1'b1;
            OP_CLR: mstack.delete();
            default: ee = 1'b1;
        endcase
    endtask

    // Called at a falling edge with in_ready high; returns at a falling edge with in_ready high
    // (or after the stall budget), with the result cycle's outputs captured.
    task automatic do_cmd(input int op, input int val);
        in_valid = 1'b1; opcode = op[3:0]; in_data = val[N-1:0];
        @(posedge clk); #1;
        in_valid = 1'b0; opcode = 4'd0; in_data = '0;
        @(negedge clk);
        busy = 0;
        while (in_ready !== 1'b1 && busy < 3 * N + 10) begin
            busy++;
            @(negedge clk);
        end
        if (in_ready !== 1'b1) busy = -1;
        ov = out_valid; od = out_data; of = overflow; er = error;
    endtask

    task automatic step(input int op, input int val);
        model_apply(op, val);
        do_cmd(op, val);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; opcode = 4'd0; in_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (sp !== '0) begin n_errors++; $display("FAIL reset_sp: got %0d want 0", sp); end
        n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_errors++; $display("FAIL reset_flags: empty=%b full=%b want 1 0", empty, full); end
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0 || error !== 1'b0 || overflow !== 1'b0 || out_data !== '0)
            begin n_errors++; $display("FAIL reset_outs: v=%b e=%b o=%b d=%0d want all 0", out_valid, error, overflow, out_data); end
        // reset must win over a simultaneous accept
        rst = 1'b1; in_valid = 1'b1; opcode = 4'd1; in_data = 4'sd3;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; opcode = 4'd0;
        @(negedge clk);
        n_checks++; if (sp !== '0 || out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_priority: sp=%0d v=%b want 0 0", sp, out_valid); end
        mstack.delete();
    endtask

    task automatic test_add_sub();
        step(OP_CLR, 0); step(OP_PUSH, 7); step(OP_PUSH, 7); step(OP_ADD, 0);
        n_checks++; if (ov !== 1'b1 || od !== 4'hE || of !== 1'b1)
            begin n_errors++; $display("FAIL add_wrap: v=%b d=%0d o=%b want 1 -2 1", ov, $signed(od), of); end
        n_checks++; if (sp !== 5'd1) begin n_errors++; $display("FAIL add_sp: got %0d want 1", sp); end
        step(OP_PUSH, 5); step(OP_SUB, 0);
        n_checks++; if (ov !== 1'b1 || od !== 4'h9 || of !== 1'b0)
            begin n_errors++; $display("FAIL sub: v=%b d=%0d o=%b want 1 -7 0", ov, $signed(od), of); end
        n_checks++; if (sp !== 5'd1) begin n_errors++; $display("FAIL sub_sp: got %0d want 1", sp); end
    endtask

    task automatic test_mul();
        step(OP_CLR, 0); step(OP_PUSH, 3); step(OP_PUSH, -2); step(OP_MUL, 0);
        n_checks++; if (busy !== N + 1) begin n_errors++; $display("FAIL mul_stall: got %0d want %0d", busy, N + 1); end
        n_checks++; if (ov !== 1'b1 || od !== 4'hA || of !== 1'b0 || sp !== 5'd1)
            begin n_errors++; $display("FAIL mul_neg: v=%b d=%0d o=%b sp=%0d want 1 -6 0 1", ov, $signed(od), of, sp); end
        step(OP_CLR, 0); step(OP_PUSH, -8); step(OP_PUSH, -1); step(OP_MUL, 0);
        n_checks++; if (ov !== 1'b1 || od !== 4'h8 || of !== 1'b1)
            begin n_errors++; $display("FAIL mul_ovf: v=%b d=%0d o=%b want 1 -8 1", ov, $signed(od), of); end
    endtask

    task automatic test_swap_pop();
        step(OP_CLR, 0); step(OP_PUSH, 1); step(OP_PUSH, 2); step(OP_SWAP, 0);
        n_checks++; if (ov !== 1'b0 || er !== 1'b0) begin n_errors++; $display("FAIL swap_pulse: v=%b e=%b want 0 0", ov, er); end
        step(OP_POP, 0);
        n_checks++; if (ov !== 1'b1 || od !== 4'h1 || of !== 1'b0) begin n_errors++; $display("FAIL pop1: v=%b d=%0d o=%b want 1 1 0", ov, $signed(od), of); end
        step(OP_POP, 0);
        n_checks++; if (ov !== 1'b1 || od !== 4'h2 || sp !== '0) begin n_errors++; $display("FAIL pop2: v=%b d=%0d sp=%0d want 1 2 0", ov, $signed(od), sp); end
        step(OP_POP, 0);
        n_checks++; if (er !== 1'b1 || ov !== 1'b0 || sp !== '0) begin n_errors++; $display("FAIL pop_empty: e=%b v=%b sp=%0d want 1 0 0", er, ov, sp); end
        step(OP_CLR, 0);
        n_checks++; if (er !== 1'b0 || ov !== 1'b0) begin n_errors++; $display("FAIL clr_empty: e=%b v=%b want 0 0", er, ov); end
        step(OP_PUSH, -8); step(OP_NEG, 0);
        n_checks++; if (ov !== 1'b1 || od !== 4'h8 || of !== 1'b1) begin n_errors++; $display("FAIL neg_min: v=%b d=%0d o=%b want 1 -8 1", ov, $signed(od), of); end
    endtask

    task automatic test_full();
        step(OP_CLR, 0);
        for (int i = 0; i < DEPTH; i++) step(OP_PUSH, $urandom_range(0, 15));
        n_checks++; if (full !== 1'b1 || sp !== 5'd16 || empty !== 1'b0)
            begin n_errors++; $display("FAIL fill: full=%b sp=%0d empty=%b want 1 16 0", full, sp, empty); end
        step(OP_PUSH, 1);
        n_checks++; if (er !== 1'b1 || ov !== 1'b0 || sp !== 5'd16) begin n_errors++; $display("FAIL push_full: e=%b v=%b sp=%0d want 1 0 16", er, ov, sp); end
        step(OP_DUP, 0);
        n_checks++; if (er !== 1'b1 || sp !== 5'd16) begin n_errors++; $display("FAIL dup_full: e=%b sp=%0d want 1 16", er, sp); end
        step(15, 0);
        n_checks++; if (er !== 1'b1 || ov !== 1'b0 || sp !== 5'd16) begin n_errors++; $display("FAIL illegal_op: e=%b v=%b sp=%0d want 1 0 16", er, ov, sp); end
        step(OP_CLR, 0); step(OP_PUSH, 5); step(OP_ADD, 0);
        n_checks++; if (er !== 1'b1 || sp !== 5'd1) begin n_errors++; $display("FAIL add_short: e=%b sp=%0d want 1 1", er, sp); end
        step(OP_POP, 0);
        n_checks++; if (ov !== 1'b1 || od !== 4'h5) begin n_errors++; $display("FAIL add_short_intact: v=%b d=%0d want 1 5", ov, $signed(od)); end
    endtask

    task automatic test_rst_mul();
        int seen;
        step(OP_CLR, 0); step(OP_PUSH, 2); step(OP_PUSH, 3);
        in_valid = 1'b1; opcode = 4'd7;
        @(posedge clk); #1;
        in_valid = 1'b0; opcode = 4'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mstack.delete();
        @(negedge clk);
        n_checks++; if (sp !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0)
            begin n_errors++; $display("FAIL rst_mul: sp=%0d rdy=%b v=%b want 0 1 0", sp, in_ready, out_valid); end
        seen = 0;
        for (int i = 0; i < 2 * N + 4; i++) begin
            if (out_valid === 1'b1) seen++;
            @(negedge clk);
        end
        n_checks++; if (seen !== 0) begin n_errors++; $display("FAIL rst_mul_ghost: out_valid seen %0d times want 0", seen); end
    endtask

    task automatic test_back_to_back();
        int op, r;
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            op = (r < 35) ? OP_PUSH : $urandom_range(0, 15);
            if (op == OP_CLR && $urandom_range(0, 3) != 0) op = OP_PUSH;
            step(op, wrapn($urandom_range(0, 15)));
            n_checks++; if (ov !== ev || er !== ee || busy !== ebusy)
                begin n_errors++; $display("FAIL rand_pulse it=%0d op=%0d: v=%b e=%b busy=%0d want %b %b %0d", it, op, ov, er, busy, ev, ee, ebusy); end
            n_checks++; if (ov === 1'b1 && er === 1'b1) begin n_errors++; $display("FAIL rand_both it=%0d: v=1 e=1 want not both", it); end
            if (ev) begin
                n_checks++; if (od !== ed[N-1:0] || of !== eo)
                    begin n_errors++; $display("FAIL rand_data it=%0d op=%0d: d=%0d o=%b want %0d %b", it, op, $signed(od), of, ed, eo); end
            end
            n_checks++; if (int'(sp) != mstack.size() || full !== (mstack.size() == DEPTH) || empty !== (mstack.size() == 0))
                begin n_errors++; $display("FAIL rand_sp it=%0d: sp=%0d full=%b empty=%b want %0d", it, sp, full, empty, mstack.size()); end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; opcode = 4'd0; in_data = '0;
        test_reset();
        test_add_sub();
        test_mul();
        test_swap_pop();
        test_full();
        test_rst_mul();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/stack_alu_param.md
# stack_alu_param

Parametrised successor to the stack-based ALU: a signed two's-complement evaluation stack of configurable width and depth with a valid/ready command port. It adds SUB/DUP/SWAP/NEG/CLR, a multi-cycle shift-add multiplier, and explicit full/empty/error status. It sits between the command sequencer and the result consumer and replaces the fixed 4-bit stack ALU.

## Interface
- N, default 4: data width in bits (signed), N >= 2.
- DEPTH, default 16: stack entries, DEPTH >= 2.
- SPW, default $clog2(DEPTH+1): stack-pointer width (5 for DEPTH=16).

- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  command present.
- in_ready  output  1  block can accept a command.
- opcode  input  4  operation, sampled on accept.
- in_data  input  N  signed operand for PUSH.
- out_valid  output  1  one-cycle pulse: out_data/overflow are valid.
- out_data  output  N  signed result.
- overflow  output  1  signed overflow of the reported result, qualified by out_valid.
- error  output  1  one-cycle pulse: the command was rejected.
- sp  output  SPW  number of occupied entries (0..DEPTH).
- full  output  1  sp == DEPTH.
- empty  output  1  sp == 0.

## Operation
- Accept happens on an edge where in_valid && in_ready. Without in_ready, the command is ignored; the sender holds it.
- Naming: T = top entry, S = entry below top. Binary ops pop T and S, then push f(S, T).
- 0000 NOP: no effect, no pulses.
- 0001 PUSH: push in_data. Requires !full.
- 0010 POP: out_data=T, pop. Requires sp>=1.
- 0011 DUP: push T. Requires sp>=1 and !full.
- 0100 SWAP: exchange T and S. Requires sp>=2. No out_valid.
- 0101 ADD: S+T. 0110 SUB: S-T. 0111 MUL: S*T. All require sp>=2. Net sp change -1.
- 1000 NEG: replace T with -T. Requires sp>=1.
- 1001 CLR: sp=0.
- 1010-1111: illegal.
- Arithmetic results are truncated to N bits (wrap) and both pushed and driven on out_data with out_valid.
- overflow=1 when the exact result is outside [-2^(N-1), 2^(N-1)-1]. Examples: NEG of -2^(N-1); a MUL product whose bits [2N-1:N-1] are not all equal.
- overflow is 0 for POP.
- Rejected commands (precondition fail or illegal opcode) leave stack, sp and outputs unchanged except that error pulses. out_valid stays 0.
- MUL algorithm: operand magnitudes go into an unsigned shift-add, one multiplier bit per cycle. The 2N-bit product is negated if the signs differ. The magnitude of -2^(N-1) fits in N unsigned bits.
- FSM states: IDLE, MUL_RUN, MUL_WB.
  - IDLE: in_ready=1.
  - Accepted MUL with sp>=2 -> MUL_RUN with a counter of N.
  - MUL_RUN: one iteration per cycle; when the counter reaches 0, go to MUL_WB.
  - MUL_WB: write the result, pulse out_valid, return to IDLE.
  - A MUL with sp<2 never leaves IDLE.
- Stack storage is not reset. Entries at index >= sp are don't-care.

## Timing
- Reset values: sp=0, empty=1, full=0, in_ready=1, out_valid=0, out_data=0, overflow=0, error=0, FSM=IDLE.
- Non-MUL ops: sp, stack, full and empty update on the accepting edge. out_valid/out_data/overflow/error are registered and visible in the cycle right after accept (latency 1). A new command may be accepted every cycle.
- MUL: accepted at edge 0.
  - in_ready is low after edge 0 through edge N+1.
  - sp changes at edge N+1.
  - out_valid pulses in the cycle after edge N+1.
  - in_ready returns to 1 in that same cycle.
- Back-to-back ops see the stack already updated by the previous op.
- out_valid and error are never high together.
- No output backpressure: the consumer must take out_data in the out_valid cycle.
- rst high on any edge forces reset values regardless of state. It aborts an in-flight MUL with no out_valid, and the stack is cleared.
- rst has priority over a simultaneous accept.
- Boundaries:
  - PUSH/DUP at sp==DEPTH: error.
  - POP/NEG at sp==0: error.
  - Binary ops at sp<2: error.
  - CLR at sp==0: legal, no pulse.

## Test plan
- Reset with N=4, DEPTH=16 -> sp=0, empty=1, full=0, in_ready=1, out_valid=0.
- PUSH 7, PUSH 7, ADD -> next cycle out_valid=1, out_data=-2, overflow=1, sp=1. Then PUSH 5, SUB -> out_data=-7, overflow=0, sp=1.
- CLR, PUSH 3, PUSH -2, MUL -> in_ready low 5 cycles, then out_data=-6, overflow=0, sp=1. Then CLR, PUSH -8, PUSH -1, MUL -> out_data=-8, overflow=1.
- PUSH 1, PUSH 2, SWAP, POP, POP -> out_data 1 then 2, sp=0. POP on empty -> error=1, sp=0. NEG on -8 -> out_data=-8, overflow=1.
- 16 PUSHes -> full=1, sp=16. 17th PUSH and a DUP -> error each, sp=16. Opcode 1111 -> error. ADD with sp=1 -> error, stack intact.
- Start MUL, assert rst at the third MUL_RUN cycle -> next cycle sp=0, in_ready=1, no out_valid ever.
